mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Edge-triggered single-port RAM access sequencer: turns level read/write requests
// from the control unit into one timed synchronous-RAM access with a Done pulse.
module mem_responder #(
   parameter int ADDR_W = 9,
   parameter int WAIT   = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [31:0]       WData,
   input  logic              ReadEn,
   input  logic              Write,
   output logic [31:0]       RData,
   output logic              Done,
   output logic              Busy,
   output logic              Err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_REQ    = 3'd1,
      RD_WAIT   = 3'd2,
      RD_CAP    = 3'd3,
      WR_WAIT   = 3'd4,
      WR_COMMIT = 3'd5,
      DONE      = 3'd6
   } state_t;

   // Counter preload; unused when WAIT is zero because the wait states are skipped.
   localparam logic [2:0] WAIT_LD = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                rd_prev_q, wr_prev_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rdata_q;
   logic                done_q, busy_q, err_q, we_q, re_q;
   logic                rd_edge_s, wr_edge_s, err_d, latch_s;

   assign rd_edge_s = ReadEn & ~rd_prev_q;
   assign wr_edge_s = Write & ~wr_prev_q;
   assign latch_s   = (state_q == IDLE) & (rd_edge_s ^ wr_edge_s);

   // State, wait counter and request history
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         cnt_q     <= 3'd0;
         rd_prev_q <= 1'b0;
         wr_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_prev_q <= ReadEn;
         wr_prev_q <= Write;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_edge_s && wr_edge_s) begin
               err_d = 1'b1;
            end else if (rd_edge_s) begin
               state_d = RD_REQ;
            end else if (wr_edge_s) begin
               if (WAIT != 0) begin
                  state_d = WR_WAIT;
                  cnt_d   = WAIT_LD;
               end else begin
                  state_d = WR_COMMIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_REQ: begin
            if (WAIT != 0) begin
               state_d = RD_WAIT;
               cnt_d   = WAIT_LD;
            end else begin
               state_d = RD_CAP;
            end
         end
         RD_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = RD_CAP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RD_CAP:    state_d = DONE;
         WR_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = WR_COMMIT;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         WR_COMMIT: state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
      end else begin
         if (latch_s) begin
            addr_q  <= Addr;
            wdata_q <= WData;
         end
         if (state_q == RD_CAP) begin
            rdata_q <= ram_rdata;
         end
         done_q <= (state_d == DONE);
         busy_q <= (state_d != IDLE);
         err_q  <= err_d;
         we_q   <= (state_d == WR_COMMIT);
         re_q   <= (state_d == RD_REQ);
      end
   end

   assign RData     = rdata_q;
   assign Done      = done_q;
   assign Busy      = busy_q;
   assign Err       = err_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign ram_we    = we_q;
   assign ram_re    = re_q;

endmodule
